fifo_to_sdram_wr_controller: RTL

Write-side controller for the FIFO that feeds the SDRAM writer. Accepts an 8-bit byte stream, packs byte pairs into 16-bit words, and issues single-cycle `wrreq` pulses into the FIFO. It throttles the source from the FIFO fill level and flags when a full SDRAM burst is buffered. It is the counterpart of the read-side controller that unpacks SDRAM words back into bytes.

---
 rtl/fifo_to_sdram_wr_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_to_sdram_wr_controller.sv
// fifo_to_sdram_wr_controller
//
// Write-side controller for the FIFO that feeds the SDRAM writer. It packs an
// 8-bit byte stream into 16-bit words and issues one single-cycle wrreq per
// word. The source is throttled from the FIFO fill level. burst_avail flags
// when a full SDRAM burst is buffered.
//
// Ports:
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   byte_in       : source byte
//   byte_valid    : byte_in valid this cycle
//   byte_ready    : controller can accept a byte (registered)
//   flush         : pad a pending odd byte with 0x00 and write it out
//   usedw         : FIFO write-side used-word count
//   wrreq         : FIFO write strobe, one cycle per word
//   data          : FIFO write data, holds its value between writes
//   burst_avail   : usedw >= BURST_LEN (registered)
//   words_written : wrapping count of words written
//   overflow      : sticky, a byte was offered while not ready and was lost
module fifo_to_sdram_wr_controller #(
    parameter int FIFO_DEPTH   = 1024,
    parameter int AFULL_MARGIN = 4,
    parameter int BURST_LEN    = 256,
    parameter bit LOW_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        flush,
    input  logic [9:0]  usedw,
    output logic        wrreq,
    output logic [15:0] data,
    output logic        burst_avail,
    output logic [15:0] words_written,
    output logic        overflow
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    // Thresholds are compared at 11 bits so usedw = 1023 can never wrap.
    localparam logic [10:0] READY_TH = 11'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [10:0] BURST_TH = 11'(BURST_LEN);

    state_t      state_q, state_d;
    logic [7:0]  lo_reg_q, lo_reg_d;
    logic        wrreq_q, wrreq_d;
    logic [15:0] data_q, data_d;
    logic        byte_ready_q, byte_ready_d;
    logic        burst_avail_q, burst_avail_d;
    logic [15:0] words_written_q, words_written_d;
    logic        overflow_q, overflow_d;

    logic        accept;
    logic [10:0] usedw_ext;

    // first is the byte that arrived earlier; LOW_FIRST decides which lane it takes.
    function automatic logic [15:0] pack_pair(input logic [7:0] first,
                                              input logic [7:0] second);
        if (LOW_FIRST)
            return {second, first};
        else
            return {first, second};
    endfunction

    assign accept    = byte_valid && byte_ready_q;
    assign usedw_ext = {1'b0, usedw};

    always_comb begin
        state_d         = state_q;
        lo_reg_d        = lo_reg_q;
        wrreq_d         = 1'b0;
        data_d          = data_q;

        unique case (state_q)
            EMPTY: begin
                if (accept && flush) begin
                    // Lone byte with flush: write it padded, no need to hold it.
                    wrreq_d = 1'b1;
                    data_d  = pack_pair(byte_in, 8'h00);
                end else if (accept) begin
                    lo_reg_d = byte_in;
                    state_d  = HALF;
                end
            end
            HALF: begin
                if (accept) begin
                    // A completing byte takes priority over flush.
                    wrreq_d = 1'b1;
                    data_d  = pack_pair(lo_reg_q, byte_in);
                    state_d = EMPTY;
                end else if (flush) begin
                    wrreq_d = 1'b1;
                    data_d  = pack_pair(lo_reg_q, 8'h00);
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Counted together with the strobe so the count and wrreq move on the same edge.
        words_written_d = wrreq_d ? words_written_q + 16'd1 : words_written_q;
        byte_ready_d    = (usedw_ext < READY_TH);
        burst_avail_d   = (usedw_ext >= BURST_TH);
        overflow_d      = overflow_q || (byte_valid && !byte_ready_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EMPTY;
            lo_reg_q        <= 8'h00;
            wrreq_q         <= 1'b0;
            data_q          <= 16'h0000;
            byte_ready_q    <= 1'b0;
            burst_avail_q   <= 1'b0;
            words_written_q <= 16'h0000;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            lo_reg_q        <= lo_reg_d;
            wrreq_q         <= wrreq_d;
            data_q          <= data_d;
            byte_ready_q    <= byte_ready_d;
            burst_avail_q   <= burst_avail_d;
            words_written_q <= words_written_d;
            overflow_q      <= overflow_d;
        end
    end

    assign wrreq         = wrreq_q;
    assign data          = data_q;
    assign byte_ready    = byte_ready_q;
    assign burst_avail   = burst_avail_q;
    assign words_written = words_written_q;
    assign overflow      = overflow_q;

endmodule
